// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one ALU between NumReq requesters.
// Flow: accept a request in IDLE, drive the ALU in EXEC, hold the tagged response in RESP.
module alu_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumReq    = 2,
  localparam int unsigned IdWidth  = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_src1_i,
  input  logic [NumReq*DataWidth-1:0] req_src2_i,
  input  logic [NumReq*4-1:0]         req_op_i,
  output logic [DataWidth-1:0]        alu_src1_o,
  output logic [DataWidth-1:0]        alu_src2_o,
  output logic [3:0]                  alu_op_o,
  input  logic [DataWidth-1:0]        alu_result_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [IdWidth-1:0]          rsp_id_o,
  output logic [DataWidth-1:0]        rsp_result_o,
  output logic                        busy_o
);

  localparam logic [IdWidth:0]   NumReqExt = (IdWidth+1)'(NumReq);
  localparam logic [IdWidth-1:0] LastId    = IdWidth'(NumReq - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic [IdWidth-1:0]   id_q;
  logic [IdWidth-1:0]   winner;
  logic [IdWidth:0]     cand;
  logic                 found;
  logic                 accept;
  logic                 capture;
  logic [DataWidth-1:0] src1_q, src2_q, result_q;
  logic [DataWidth-1:0] sel_src1, sel_src2;
  logic [3:0]           op_q, sel_op;

  // First valid requester at or above ptr, wrapping at NumReq.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_q} + (IdWidth+1)'(i);
      if (cand >= NumReqExt) cand = cand - NumReqExt;
      if (!found && req_valid_i[cand[IdWidth-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdWidth-1:0];
      end
    end
  end

  // Winner's operand/opcode mux.
  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    sel_op   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (winner == IdWidth'(k)) begin
        sel_src1 = req_src1_i[k*DataWidth +: DataWidth];
        sel_src2 = req_src2_i[k*DataWidth +: DataWidth];
        sel_op   = req_op_i[k*4 +: 4];
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    accept      = 1'b0;
    capture     = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          accept      = 1'b1;
          req_ready_o = NumReq'(1) << winner;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          ptr_d   = (id_q == LastId) ? '0 : id_q + IdWidth'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        id_q   <= winner;
        src1_q <= sel_src1;
        src2_q <= sel_src2;
        op_q   <= sel_op;
      end
      if (capture) result_q <= alu_result_i;
    end
  end

  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign alu_op_o     = op_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign busy_o       = (state_q != IDLE);

endmodule
